stage_score_ctrl: RTL and testbench

- Sits directly downstream of the player-bullet hit logic. Consumes its per-hit strobes (shot_enm, shot_boss) and the enemy/boss HP registers.
- Runs the stage sequencing FSM: idle → enemy wave → boss → clear/over.
- Tracks alive flags for the four enemies and the boss, and accumulates a saturating score.
- Converts the score to 4-digit BCD with a multi-cycle shift-add-3 engine for the seven-segment/VGA score display.

---
 rtl/stage_score_if.sv | 19 +
 rtl/stage_score_ctrl.sv | 112 +++++++++++
 tb/tb_stage_score_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/stage_score_if.sv
// stage_score_if: hit strobes and HP levels in; stage, alive and score status out.
interface stage_score_if;
  logic gamestart, shot_enm, shot_boss, reimu_dead;
  logic [6:0] enmhp1, enmhp2, enmhp3, enmhp4;
  logic [9:0] bosshp;
  logic [1:0] state;
  logic [3:0] enm_alive;
  logic boss_active, stage_clear, game_over, bcd_busy;
  logic [13:0] score_bin;
  logic [15:0] score_bcd;
  modport master (
    output gamestart, shot_enm, shot_boss, reimu_dead, enmhp1, enmhp2, enmhp3, enmhp4, bosshp,
    input  state, enm_alive, boss_active, stage_clear, game_over, score_bin, score_bcd, bcd_busy
  );
  modport slave (
    input  gamestart, shot_enm, shot_boss, reimu_dead, enmhp1, enmhp2, enmhp3, enmhp4, bosshp,
    output state, enm_alive, boss_active, stage_clear, game_over, score_bin, score_bcd, bcd_busy
  );
endinterface

// File: rtl/stage_score_ctrl.sv
// stage_score_ctrl: stage sequencing FSM, saturating score and multi-cycle score-to-BCD conversion.
module stage_score_ctrl #(
  parameter int PTS_HIT       = 1,
  parameter int PTS_ENM_KILL  = 50,
  parameter int PTS_BOSS_KILL = 500,
  parameter int SCORE_MAX     = 9999
) (
  input logic clk_22,
  input logic rst,
  stage_score_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAVE, BOSS, ENDS} stage_t;
  typedef enum logic [1:0] {CIDLE, LOAD, SHIFT, DONE} conv_t;
  stage_t st, st_nx;
  conv_t cs, cs_nx;
  logic [3:0] alive, alive_nx, kills;
  logic clear, clear_nx, over, over_nx, boss_kill, playing;
  logic [13:0] score, score_nx, conv_val, snap, sh;
  logic [15:0] work, bcd;
  logic [3:0] cnt;
  int delta, sum;
  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = v[4*i +: 4] >= 4'd5 ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    return r;
  endfunction
  always_comb begin
    playing = st == WAVE || st == BOSS;
    kills = st == WAVE ? alive & {bus.enmhp4 == 7'd0, bus.enmhp3 == 7'd0, bus.enmhp2 == 7'd0, bus.enmhp1 == 7'd0} : 4'b0;
    boss_kill = st == BOSS && bus.bosshp == 10'd0;
    delta = (bus.shot_enm ? PTS_HIT : 0) + (bus.shot_boss && st == BOSS ? PTS_HIT : 0)
          + PTS_ENM_KILL * $countones(kills) + (boss_kill ? PTS_BOSS_KILL : 0);
    sum = int'(score) + delta;
    st_nx = st;
    alive_nx = alive;
    clear_nx = clear;
    over_nx = over;
    score_nx = score;
    if (bus.gamestart) begin
      st_nx = WAVE;
      alive_nx = 4'hf;
      score_nx = 14'd0;
      clear_nx = 1'b0;
      over_nx = 1'b0;
    end else if (playing && bus.reimu_dead) begin
      // death wins over any kill this cycle, and its points are dropped
      st_nx = ENDS;
      over_nx = 1'b1;
    end else if (playing) begin
      alive_nx = alive & ~kills;
      score_nx = sum > SCORE_MAX ? 14'(SCORE_MAX) : 14'(sum);
      st_nx = boss_kill ? ENDS : (st == WAVE && alive == 4'b0) ? BOSS : st;
      clear_nx = clear | boss_kill;
    end
  end
  always_ff @(posedge clk_22) begin
    if (rst) begin
      st <= IDLE;
      alive <= 4'b0;
      clear <= 1'b0;
      over <= 1'b0;
      score <= 14'd0;
    end else begin
      st <= st_nx;
      alive <= alive_nx;
      clear <= clear_nx;
      over <= over_nx;
      score <= score_nx;
    end
  end
  always_comb
    cs_nx = cs == CIDLE ? (score != conv_val ? LOAD : CIDLE) :
            cs == LOAD  ? SHIFT :
            cs == SHIFT ? (cnt == 4'd13 ? DONE : SHIFT) : CIDLE;
  // score_bcd only updates in DONE, so the display never sees a half-shifted value
  always_ff @(posedge clk_22) begin
    if (rst) begin
      cs <= CIDLE;
      cnt <= 4'd0;
      work <= 16'd0;
      sh <= 14'd0;
      snap <= 14'd0;
      conv_val <= 14'd0;
      bcd <= 16'd0;
    end else begin
      cs <= cs_nx;
      if (cs == LOAD) begin
        snap <= score;
        sh <= score;
        work <= 16'd0;
        cnt <= 4'd0;
      end
      if (cs == SHIFT) begin
        {work, sh} <= {add3(work), sh} << 1;
        cnt <= cnt + 4'd1;
      end
      if (cs == DONE) begin
        bcd <= work;
        conv_val <= snap;
      end
    end
  end
  assign bus.state = st;
  assign bus.enm_alive = alive;
  assign bus.boss_active = st == BOSS;
  assign bus.stage_clear = clear;
  assign bus.game_over = over;
  assign bus.score_bin = score;
  assign bus.score_bcd = bcd;
  assign bus.bcd_busy = cs != CIDLE;
endmodule

// File: tb/tb_stage_score_ctrl.sv
// tb_stage_score_ctrl: directed plan plus random play on two instances (SCORE_MAX 9999 and 100) against a rule-level model.
module tb_stage_score_ctrl;
  logic clk_22 = 1'b0, rst = 1'b1;
  logic gamestart = 0, shot_enm = 0, shot_boss = 0, reimu_dead = 0;
  logic [6:0] hp[4] = '{7'd10, 7'd10, 7'd10, 7'd10};
  logic [9:0] bosshp = 10'd100;
  int n_pass = 0, n_chk = 0;
  int mx[2] = '{9999, 100};
  int m_stage = 0, m_score[2] = '{0, 0};
  bit [3:0] m_alive = 0;
  bit m_clear = 0, m_over = 0;
  logic [1:0] o_state[2];
  logic [3:0] o_alive[2];
  logic o_boss[2], o_clear[2], o_over[2], o_busy[2];
  logic [13:0] o_score[2];
  logic [15:0] o_bcd[2];
  stage_score_if b0 (), b1 ();
  stage_score_ctrl u0 (.clk_22(clk_22), .rst(rst), .bus(b0.slave));
  stage_score_ctrl #(.SCORE_MAX(100)) u1 (.clk_22(clk_22), .rst(rst), .bus(b1.slave));
  always #5 clk_22 = ~clk_22;
  assign {b0.gamestart, b0.shot_enm, b0.shot_boss, b0.reimu_dead} = {gamestart, shot_enm, shot_boss, reimu_dead};
  assign {b1.gamestart, b1.shot_enm, b1.shot_boss, b1.reimu_dead} = {gamestart, shot_enm, shot_boss, reimu_dead};
  assign {b0.enmhp1, b0.enmhp2, b0.enmhp3, b0.enmhp4, b0.bosshp} = {hp[0], hp[1], hp[2], hp[3], bosshp};
  assign {b1.enmhp1, b1.enmhp2, b1.enmhp3, b1.enmhp4, b1.bosshp} = {hp[0], hp[1], hp[2], hp[3], bosshp};
  assign {o_state[0], o_alive[0], o_boss[0], o_clear[0], o_over[0], o_busy[0], o_score[0], o_bcd[0]} =
         {b0.state, b0.enm_alive, b0.boss_active, b0.stage_clear, b0.game_over, b0.bcd_busy, b0.score_bin, b0.score_bcd};
  assign {o_state[1], o_alive[1], o_boss[1], o_clear[1], o_over[1], o_busy[1], o_score[1], o_bcd[1]} =
         {b1.state, b1.enm_alive, b1.boss_active, b1.stage_clear, b1.game_over, b1.bcd_busy, b1.score_bin, b1.score_bcd};
  function automatic logic [15:0] dec(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  // one clock edge of the game rules, applied to the inputs present before the edge
  task automatic model_edge();
    int kills, pts, nxt;
    bit bk;
    if (rst) begin
      m_stage = 0; m_alive = 0; m_clear = 0; m_over = 0; m_score = '{0, 0};
    end else if (gamestart) begin
      m_stage = 1; m_alive = 4'hf; m_clear = 0; m_over = 0; m_score = '{0, 0};
    end else if ((m_stage == 1 || m_stage == 2) && reimu_dead) begin
      m_stage = 3; m_over = 1;
    end else if (m_stage == 1 || m_stage == 2) begin
      kills = 0;
      nxt = m_stage;
      if (m_stage == 1) begin
        if (m_alive == 0) nxt = 2;
        for (int i = 0; i < 4; i++)
          if (m_alive[i] && hp[i] == 0) begin kills++; m_alive[i] = 0; end
      end
      bk = m_stage == 2 && bosshp == 0;
      if (bk) begin nxt = 3; m_clear = 1; end
      pts = int'(shot_enm) + int'(shot_boss && m_stage == 2) + 50 * kills + 500 * int'(bk);
      for (int k = 0; k < 2; k++) m_score[k] = m_score[k] + pts > mx[k] ? mx[k] : m_score[k] + pts;
      m_stage = nxt;
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk_22); model_edge(); #1; end
  endtask
  task automatic cmp(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s[u%0d] got=%0d expected=%0d", tag, k, got, exp);
  endtask
  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      cmp({tag, ".state"}, k, 32'(o_state[k]), 32'(m_stage));
      cmp({tag, ".alive"}, k, 32'(o_alive[k]), 32'(m_alive));
      cmp({tag, ".boss_active"}, k, 32'(o_boss[k]), 32'(m_stage == 2));
      cmp({tag, ".clear"}, k, 32'(o_clear[k]), 32'(m_clear));
      cmp({tag, ".over"}, k, 32'(o_over[k]), 32'(m_over));
      cmp({tag, ".score"}, k, 32'(o_score[k]), 32'(m_score[k]));
    end
  endtask
  task automatic check_bcd(input string tag);
    cyc(32);
    for (int k = 0; k < 2; k++) begin
      cmp({tag, ".bcd"}, k, 32'(o_bcd[k]), 32'(dec(m_score[k])));
      cmp({tag, ".busy"}, k, 32'(o_busy[k]), 0);
    end
  endtask
  task automatic pulse_enm(); shot_enm = 1; cyc(); shot_enm = 0; cyc(); endtask
  task automatic pulse_boss(); shot_boss = 1; cyc(); shot_boss = 0; cyc(); endtask
  task automatic restart();
    hp = '{7'd10, 7'd10, 7'd10, 7'd10}; bosshp = 10'd100;
    gamestart = 1; cyc(); gamestart = 0;
  endtask
  initial begin
    #1;
    cyc(2); rst = 0; cyc(20);
    check_all("reset");
    cmp("reset.state0", 0, 32'(o_state[0]), 0);
    check_bcd("reset");
    restart();
    repeat (3) pulse_enm();
    check_all("wave3");
    cmp("wave3.score", 0, 32'(o_score[0]), 3);
    cmp("wave3.alive", 0, 32'(o_alive[0]), 4'hf);
    check_bcd("wave3");
    cmp("wave3.bcd", 0, 32'(o_bcd[0]), 16'h0003);
    pulse_boss();
    cmp("wave_boss_shot", 0, 32'(o_score[0]), 3);
    hp[1] = 0; cyc(10);
    check_all("kill2");
    cmp("kill2.score", 0, 32'(o_score[0]), 53);
    cmp("kill2.alive", 0, 32'(o_alive[0]), 4'b1101);
    hp[0] = 0; hp[2] = 0; hp[3] = 0; cyc();
    check_all("kill3x");
    cmp("kill3x.score", 0, 32'(o_score[0]), 203);
    cyc();
    check_all("to_boss");
    cmp("to_boss.state", 0, 32'(o_state[0]), 2);
    pulse_boss();
    cmp("boss_hit", 0, 32'(o_score[0]), 204);
    bosshp = 0; cyc(); bosshp = 100;
    check_all("boss_kill");
    cmp("boss_kill.score", 0, 32'(o_score[0]), 704);
    cmp("boss_kill.clear", 0, 32'(o_clear[0]), 1);
    pulse_enm(); pulse_boss();
    check_all("end_hold");
    check_bcd("end");
    cmp("end.bcd", 0, 32'(o_bcd[0]), 16'h0704);
    restart();
    hp = '{7'd0, 7'd0, 7'd0, 7'd0}; cyc(2);
    bosshp = 0; reimu_dead = 1; cyc(); reimu_dead = 0; bosshp = 100;
    check_all("dead");
    cmp("dead.over", 0, 32'(o_over[0]), 1);
    cmp("dead.clear", 0, 32'(o_clear[0]), 0);
    cmp("dead.score", 0, 32'(o_score[0]), 200);
    restart();
    check_all("restart");
    check_bcd("restart");
    for (int i = 0; i < 3; i++) begin
      hp[i] = 0; cyc();
      check_all("sat_kill");
      cmp("sat_kill.score", 1, 32'(o_score[1]), i == 0 ? 50 : 100);
    end
    check_bcd("sat");
    cmp("sat.bcd", 1, 32'(o_bcd[1]), 16'h0100);
    pulse_enm(); cyc();
    cmp("busy_mid", 0, 32'(o_busy[0]), 1);
    rst = 1; cyc(); rst = 0;
    check_all("rst_mid");
    for (int k = 0; k < 2; k++) begin
      cmp("rst_mid.bcd", k, 32'(o_bcd[k]), 0);
      cmp("rst_mid.busy", k, 32'(o_busy[k]), 0);
    end
    for (int n = 0; n < 4000; n++) begin
      gamestart = $urandom_range(199) == 0;
      shot_enm = $urandom_range(3) == 0;
      shot_boss = $urandom_range(3) == 0;
      reimu_dead = $urandom_range(249) == 0;
      for (int i = 0; i < 4; i++) hp[i] = $urandom_range(19) == 0 ? 7'd0 : 7'($urandom_range(1, 100));
      bosshp = $urandom_range(29) == 0 ? 10'd0 : 10'($urandom_range(1, 999));
      cyc();
      check_all("rand");
      if (n % 500 == 499) begin
        {gamestart, shot_enm, shot_boss, reimu_dead} = 4'b0;
        hp = '{7'd9, 7'd9, 7'd9, 7'd9}; bosshp = 10'd9;
        check_bcd("rand");
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
